// File: rtl/unfunnel_buffered_if.sv
// Handshake bundle for unfunnel_buffered: one word stream in, funnel_width lanes out.
// The slave modport is the unfunnel itself; master is the surrounding environment.
interface unfunnel_buffered_if #(
  parameter int unsigned FUNNEL_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 32
);
  localparam int unsigned IW = (FUNNEL_WIDTH > 1) ? $clog2(FUNNEL_WIDTH) : 1;

  logic                               enq_ena;
  logic [DATA_WIDTH-1:0]              enq_v;
  logic [IW-1:0]                      enq_dest;
  logic                               enq_bcast;
  logic                               enq_rdy_c;
  logic [FUNNEL_WIDTH-1:0]            deq_ena_c;
  logic [FUNNEL_WIDTH*DATA_WIDTH-1:0] deq_v_c;
  logic [FUNNEL_WIDTH-1:0]            deq_rdy;
  logic [15:0]                        drop_count;

  modport master (
    output enq_ena, enq_v, enq_dest, enq_bcast, deq_rdy,
    input  enq_rdy_c, deq_ena_c, deq_v_c, drop_count
  );

  modport slave (
    input  enq_ena, enq_v, enq_dest, enq_bcast, deq_rdy,
    output enq_rdy_c, deq_ena_c, deq_v_c, drop_count
  );
endinterface

// File: rtl/unfunnel_buffered.sv
// Steers one word stream to per-lane FIFOs (unicast or broadcast); words for a
// non-existent lane are dropped and counted.
module unfunnel_buffered #(
  parameter int unsigned FUNNEL_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  unfunnel_buffered_if.slave bus
);
  localparam int unsigned IW = (FUNNEL_WIDTH > 1) ? $clog2(FUNNEL_WIDTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0]   mem    [FUNNEL_WIDTH][DEPTH];
  logic [PW-1:0]           rd_ptr [FUNNEL_WIDTH];
  logic [PW-1:0]           wr_ptr [FUNNEL_WIDTH];
  logic [CW-1:0]           count  [FUNNEL_WIDTH];
  logic [15:0]             drop_count;

  logic [FUNNEL_WIDTH-1:0] lane_full;
  logic [FUNNEL_WIDTH-1:0] push;
  logic [FUNNEL_WIDTH-1:0] pop;
  logic                    dest_valid;
  logic                    dest_full;
  logic                    enq_rdy_c;
  logic                    accept;
  logic [FUNNEL_WIDTH*DATA_WIDTH-1:0] deq_v_c;

  // Ready depends only on registered counts and dest/bcast, never on enq_ena.
  always_comb begin
    lane_full  = '0;
    push       = '0;
    pop        = '0;
    deq_v_c    = '0;
    dest_valid = 1'b0;
    dest_full  = 1'b0;
    for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) begin
      lane_full[i] = (count[i] == CW'(DEPTH));
      if (bus.enq_dest == IW'(i)) begin
        dest_valid = 1'b1;
        dest_full  = lane_full[i];
      end
    end
    if (bus.enq_bcast)
      enq_rdy_c = ~|lane_full;
    else if (dest_valid)
      enq_rdy_c = ~dest_full;
    else
      enq_rdy_c = 1'b1;
    accept = bus.enq_ena & enq_rdy_c;
    for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) begin
      push[i] = accept & (bus.enq_bcast | (bus.enq_dest == IW'(i)));
      pop[i]  = (count[i] != '0) & bus.deq_rdy[i];
      deq_v_c[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][rd_ptr[i]];
    end
  end

  // Lane bookkeeping; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      drop_count <= '0;
    end else begin
      for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
        if (push[i] && !pop[i])
          count[i] <= count[i] + CW'(1);
        else if (!push[i] && pop[i])
          count[i] <= count[i] - CW'(1);
      end
      if (accept && !bus.enq_bcast && !dest_valid && (drop_count != 16'hFFFF))
        drop_count <= drop_count + 16'd1;
    end
  end

  // Payload storage needs no reset: counts gate visibility.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < FUNNEL_WIDTH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= bus.enq_v;
    end
  end

  assign bus.enq_rdy_c  = enq_rdy_c;
  assign bus.deq_ena_c  = pop;
  assign bus.deq_v_c    = deq_v_c;
  assign bus.drop_count = drop_count;
endmodule
